spi_cmd_sequencer: RTL and testbench

// Upstream command front-end for the SPI master/memory top (wr/addr/din in, dout/done/err out).

---
 rtl/spi_cmd_sequencer_pkg.sv | 27 ++
 rtl/spi_cmd_sequencer_fifo.sv | 55 +++++
 rtl/spi_cmd_sequencer.sv | 110 +++++++++++
 tb/tb_spi_cmd_sequencer.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_cmd_sequencer_pkg.sv
// Shared types and constants for the SPI command front-end.
package spi_pkg;

    localparam logic [7:0] FILL_ADDR = 8'hFF;
    localparam int         MEM_WORDS = 32;

    typedef struct packed {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
    } cmd_t;

    typedef struct packed {
        logic       wr;
        logic [7:0] rdata;
        logic       err;
    } rsp_t;

    typedef enum logic {
        FILL   = 1'b0,
        ACTIVE = 1'b1
    } seq_state_t;

    // Out-of-range read: the master answers with its error path and touches nothing.
    localparam cmd_t FILLER_CMD = '{wr: 1'b0, addr: FILL_ADDR, data: 8'h00};

endpackage

// File: rtl/spi_cmd_sequencer_fifo.sv
// Synchronous FIFO with read/write pointers and an occupancy count.
module sync_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  T                           din,
    input  logic                       pop,
    output T                           dout,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    T               mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           full;
    logic           empty;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when a pop frees the slot on the same edge.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Queues commands for the free-running SPI master and returns responses in order.
//   state  | meaning
//   FILL   | filler command in flight, its completion is discarded
//   ACTIVE | real command in flight, its completion becomes a response
module spi_cmd_sequencer
    import spi_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_wr,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       rsp_wr,
    output logic       spi_wr,
    output logic [7:0] spi_addr,
    output logic [7:0] spi_din,
    input  logic [7:0] spi_dout,
    input  logic       spi_done,
    input  logic       spi_err,
    output logic       busy
);

    localparam int CCW = $clog2(CMD_DEPTH+1);
    localparam int RCW = $clog2(RSP_DEPTH+1);

    seq_state_t     state;
    cmd_t           spi_cmd;
    cmd_t           cmd_in;
    cmd_t           cmd_head;
    rsp_t           rsp_in;
    rsp_t           rsp_head;
    logic [CCW-1:0] cmd_count;
    logic [RCW-1:0] rsp_count;
    logic [RCW:0]   rsp_next_occ;
    logic           cmd_push;
    logic           cmd_pop;
    logic           rsp_push;
    logic           rsp_pop;
    logic           rsp_room;

    assign cmd_ready = (cmd_count != CCW'(CMD_DEPTH));
    assign cmd_push  = cmd_valid && cmd_ready;
    assign cmd_in    = '{wr: cmd_wr, addr: cmd_addr, data: cmd_wdata};

    assign rsp_valid = (rsp_count != '0);
    assign rsp_pop   = rsp_ready && rsp_valid;
    assign rsp_push  = spi_done && (state == ACTIVE);
    assign rsp_in    = '{wr: spi_cmd.wr, rdata: (spi_cmd.wr ? 8'h00 : spi_dout), err: spi_err};

    // Launch only if the response this command will produce is guaranteed a slot.
    assign rsp_next_occ = {1'b0, rsp_count} + (RCW+1)'(rsp_push) - (RCW+1)'(rsp_pop);
    assign rsp_room     = (rsp_next_occ < (RCW+1)'(RSP_DEPTH));
    assign cmd_pop      = spi_done && (cmd_count != '0) && rsp_room;

    assign rsp_wr    = rsp_head.wr;
    assign rsp_rdata = rsp_head.rdata;
    assign rsp_err   = rsp_head.err;

    assign spi_wr   = spi_cmd.wr;
    assign spi_addr = spi_cmd.addr;
    assign spi_din  = spi_cmd.data;

    assign busy = (state == ACTIVE) || (cmd_count != '0);

    sync_fifo #(.T(cmd_t), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_push),
        .din   (cmd_in),
        .pop   (cmd_pop),
        .dout  (cmd_head),
        .count (cmd_count)
    );

    sync_fifo #(.T(rsp_t), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rsp_push),
        .din   (rsp_in),
        .pop   (rsp_pop),
        .dout  (rsp_head),
        .count (rsp_count)
    );

    // The master is idle on the done edge, so the command may change only then.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FILL;
            spi_cmd <= FILLER_CMD;
        end else if (spi_done) begin
            if (cmd_pop) begin
                state   <= ACTIVE;
                spi_cmd <= cmd_head;
            end else begin
                state   <= FILL;
                spi_cmd <= FILLER_CMD;
            end
        end
    end

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Bench for spi_cmd_sequencer with a behavioural SPI master and an in-order response scoreboard.
module tb_spi_cmd_sequencer;
    import spi_pkg::*;

    localparam int OP_LEN = 6;
    localparam int TMO    = 400;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_wr = 1'b0;
    logic [7:0] cmd_addr = 8'h00;
    logic [7:0] cmd_wdata = 8'h00;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       rsp_wr;
    logic       spi_wr;
    logic [7:0] spi_addr;
    logic [7:0] spi_din;
    logic [7:0] spi_dout;
    logic       spi_done;
    logic       spi_err;
    logic       busy;

    spi_cmd_sequencer #(.CMD_DEPTH(4), .RSP_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_wr    (cmd_wr),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .rsp_wr    (rsp_wr),
        .spi_wr    (spi_wr),
        .spi_addr  (spi_addr),
        .spi_din   (spi_din),
        .spi_dout  (spi_dout),
        .spi_done  (spi_done),
        .spi_err   (spi_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Master model: runs back to back, latches spi_* three edges after done, completes OP_LEN later.
    logic [7:0] m_mem [MEM_WORDS];
    int         m_wait;
    int         m_op;
    cmd_t       m_cap;

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) m_mem[i] = 8'h00;
        spi_done = 1'b0;
        spi_dout = 8'h00;
        spi_err  = 1'b0;
        m_wait   = 0;
        m_op     = 0;
        m_cap    = '0;
        forever begin
            @(posedge clk);
            #2;
            spi_done = 1'b0;
            spi_err  = 1'b0;
            if (rst) begin
                m_wait = 3;
                m_op   = 0;
            end else if (m_wait > 0) begin
                m_wait--;
                if (m_wait == 0) begin
                    m_cap = '{wr: spi_wr, addr: spi_addr, data: spi_din};
                    m_op  = OP_LEN;
                end
            end else if (m_op > 0) begin
                m_op--;
                if (m_op == 0) begin
                    spi_done = 1'b1;
                    if (m_cap.addr >= 8'(MEM_WORDS)) begin
                        spi_err  = 1'b1;
                        spi_dout = 8'h00;
                    end else if (m_cap.wr) begin
                        m_mem[m_cap.addr[4:0]] = m_cap.data;
                        spi_dout = 8'($urandom);
                    end else begin
                        spi_dout = m_mem[m_cap.addr[4:0]];
                    end
                    m_wait = 3;
                end
            end
        end
    end

    // Reference: a response is a pure function of the command and prior writes, in issue order.
    logic [7:0] ref_mem [MEM_WORDS];
    rsp_t       exp_q [$];
    rsp_t       sb_e;

    function automatic rsp_t ref_rsp(input logic wr, input logic [7:0] addr, input logic [7:0] data);
        rsp_t r;
        r.wr    = wr;
        r.err   = (addr >= 8'(MEM_WORDS));
        r.rdata = 8'h00;
        if (!r.err) begin
            if (wr) ref_mem[addr[4:0]] = data;
            else    r.rdata = ref_mem[addr[4:0]];
        end
        return r;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = m_mem[i];
            end else begin
                if (rsp_valid && rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL sb_unexpected: got response %0h, required none", {rsp_wr, rsp_rdata, rsp_err});
                    end else begin
                        sb_e = exp_q.pop_front();
                        check("sb_rsp", {rsp_wr, rsp_rdata, rsp_err}, sb_e);
                    end
                end
                if (cmd_valid && cmd_ready) exp_q.push_back(ref_rsp(cmd_wr, cmd_addr, cmd_wdata));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic wr, input logic [7:0] a, input logic [7:0] d);
        int t;
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        t = 0;
        @(negedge clk);
        while (!cmd_ready && t < TMO) begin
            t++;
            @(negedge clk);
        end
        if (!cmd_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_timeout: cmd_ready=0, required 1 within %0d cycles", TMO);
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int t;
        t = 0;
        @(negedge clk);
        while (!rsp_valid && t < TMO) begin
            t++;
            @(negedge clk);
        end
        if (!rsp_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL rsp_timeout: rsp_valid=0, required 1 within %0d cycles", TMO);
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while ((busy || rsp_valid) && t < TMO) begin
            t++;
            @(negedge clk);
        end
        if (busy || rsp_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout: busy=%0b rsp_valid=%0b, required 0 0", busy, rsp_valid);
        end
        tick();
    endtask

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
        logic       exp_err;
    } vec_t;

    vec_t vecs [8];
    int   idle_bad;
    int   occ;
    int   stage;
    int   ready_bad;
    int   n_pop;
    logic acc;
    logic pop;
    logic rand_done;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time exhausted, required end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 8'd5,   8'hA5, 8'h00, 1'b0};
        vecs[1] = '{1'b0, 8'd5,   8'h00, 8'hA5, 1'b0};
        vecs[2] = '{1'b1, 8'd40,  8'h01, 8'h00, 1'b1};
        vecs[3] = '{1'b0, 8'd0,   8'h00, 8'h00, 1'b0};
        vecs[4] = '{1'b1, 8'd31,  8'h3C, 8'h00, 1'b0};
        vecs[5] = '{1'b0, 8'd31,  8'h00, 8'h3C, 1'b0};
        vecs[6] = '{1'b0, 8'd32,  8'h00, 8'h00, 1'b1};
        vecs[7] = '{1'b1, 8'hFF,  8'h12, 8'h00, 1'b1};

        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_spi_addr", spi_addr, 8'hFF);
        check("rst_spi_wr", spi_wr, 0);
        check("rst_spi_din", spi_din, 8'h00);
        check("rst_busy", busy, 0);
        tick();
        rst = 1'b0;

        idle_bad = 0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (spi_addr !== 8'hFF || spi_wr !== 1'b0 || rsp_valid !== 1'b0) idle_bad++;
        end
        check("idle_quiet_cycles", idle_bad, 0);
        tick();

        for (int i = 0; i < 8; i++) begin
            push_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            wait_rsp();
            check($sformatf("vec%0d_rsp", i), {rsp_wr, rsp_rdata, rsp_err},
                  {vecs[i].wr, vecs[i].exp_rdata, vecs[i].exp_err});
            tick();
        end
        wait_idle();

        // Backpressure: four responses park, four commands wait, master falls back to filler.
        rsp_ready = 1'b0;
        push_cmd(1'b0, 8'd5,  8'h00);
        push_cmd(1'b0, 8'd31, 8'h00);
        for (int i = 0; i < 6; i++) push_cmd(1'b0, 8'(i), 8'h00);
        repeat (30) tick();
        @(negedge clk);
        check("bp_cmd_ready", cmd_ready, 0);
        check("bp_rsp_valid", rsp_valid, 1);
        check("bp_spi_addr", spi_addr, 8'hFF);
        check("bp_busy", busy, 1);
        tick();
        rsp_ready = 1'b1;
        n_pop = 0;
        for (int i = 0; i < TMO && n_pop < 8; i++) begin
            @(negedge clk);
            if (rsp_valid) n_pop++;
        end
        check("bp_rsp_count", n_pop, 8);
        tick();
        wait_idle();

        // Full FIFO: a pop on the same edge must not open the door for that beat.
        occ = 0;
        stage = 0;
        ready_bad = 0;
        cmd_valid = 1'b1;
        cmd_wr = 1'b1;
        cmd_addr = 8'd10;
        cmd_wdata = 8'($urandom);
        for (int c = 0; c < TMO && stage < 2; c++) begin
            @(negedge clk);
            acc = cmd_valid && cmd_ready;
            pop = spi_done && (occ > 0);
            if (cmd_ready !== (occ < 4)) ready_bad++;
            if (stage == 1) begin
                check("full_edge_next_accept", cmd_ready, 1);
                stage = 2;
            end else if (occ == 4 && spi_done) begin
                check("full_edge_refused", cmd_ready, 0);
                stage = 1;
            end
            occ = occ + int'(acc) - int'(pop);
            tick();
            if (acc) begin
                cmd_addr  = 8'(10 + c % 8);
                cmd_wdata = 8'($urandom);
            end
        end
        cmd_valid = 1'b0;
        check("full_edge_reached", stage, 2);
        check("full_edge_ready_track", ready_bad, 0);
        wait_idle();

        // Reset while a write is in flight: nothing from it may surface.
        push_cmd(1'b1, 8'd3, 8'h77);
        begin
            int t;
            t = 0;
            @(negedge clk);
            while (!(spi_wr && spi_addr == 8'd3) && t < TMO) begin
                t++;
                @(negedge clk);
            end
            check("mid_rst_launched", {spi_wr, spi_addr}, {1'b1, 8'd3});
        end
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_cmd_ready", cmd_ready, 1);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_spi_addr", spi_addr, 8'hFF);
        check("mid_rst_busy", busy, 0);
        idle_bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) idle_bad++;
        end
        check("mid_rst_no_stale_rsp", idle_bad, 0);
        tick();

        // Random traffic against the scoreboard with a stuttering consumer.
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    push_cmd(1'($urandom), 8'($urandom_range(0, 39)), 8'($urandom));
                    repeat ($urandom_range(0, 3)) tick();
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    tick();
                    rsp_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        rsp_ready = 1'b1;
        wait_idle();
        check("sb_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
